// File: rtl/rc4_pkg.sv
// Shared types for the RC4 decrypt engine.
//   mem_sel_t        : memory-handler target (none / S RAM / decrypted RAM / encrypted ROM)
//   rc4_dec_state_t  : decrypt FSM states
//   is_valid_char()  : plaintext byte is a lowercase letter or a space
package rc4_pkg;

   localparam int MSG_LEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      MEM_NONE = 2'b00,
      MEM_S    = 2'b01,
      MEM_DEC  = 2'b10,
      MEM_ENC  = 2'b11
   } mem_sel_t;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_RD_SI  = 4'd1,
      ST_RD_SJ  = 4'd2,
      ST_WR_SI  = 4'd3,
      ST_WR_SJ  = 4'd4,
      ST_RD_F   = 4'd5,
      ST_RD_ENC = 4'd6,
      ST_WR_DEC = 4'd7,
      ST_NEXT   = 4'd8,
      ST_DONE   = 4'd9
   } rc4_dec_state_t;

   function automatic logic is_valid_char(input logic [7:0] b);
      return ((b >= 8'h61) && (b <= 8'h7a)) || (b == 8'h20);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable down-counter that marks the last cycle of a memory read.
//   clk    : system clock
//   reset  : synchronous, active-high; counter cleared
//   load   : reload the counter with READ_WAIT (asserted on entry to a read state)
//   last   : high while the counter is zero, i.e. rd_data may be captured this cycle
module mem_wait_timer #(
   parameter int READ_WAIT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic last
);

   localparam int CW = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(READ_WAIT);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= RELOAD;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - CW'(1);
      end
   end

   assign last = (count_reg == '0);

endmodule

// File: rtl/rc4_decrypt_fsm.sv
// RC4 PRGA decrypt engine acting as a requester on the shared memory handler.
// Per byte: read S[i], read S[j], swap them, read S[S[i]+S[j]], read the ciphertext
// byte, write plaintext to the decrypted RAM.
//   clk, reset           : clock, synchronous active-high reset
//   start                : level, sampled only in IDLE
//   busy / done          : run in progress / one-cycle completion pulse
//   bad_char             : sticky, a plaintext byte fell outside 'a'..'z' and ' '
//   mem_sel/address/data : registered request lines to the memory handler
//   mem_wren             : one-cycle write strobe
//   rd_data              : read data returned for the current request
module rc4_decrypt_fsm
   import rc4_pkg::*;
#(
   parameter int MSG_LEN          = MSG_LEN_DEFAULT,
   parameter int READ_WAIT        = 1,
   parameter bit ABORT_ON_INVALID = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       bad_char,
   output logic [1:0] mem_sel,
   output logic [7:0] mem_address,
   output logic [7:0] mem_data,
   output logic       mem_wren,
   input  logic [7:0] rd_data
);

   localparam int KW = $clog2(MSG_LEN);
   localparam logic [KW-1:0] K_LAST = KW'(MSG_LEN - 1);

   rc4_dec_state_t state_reg, state_next;
   logic [7:0]     i_reg, i_next, j_reg, j_next;
   logic [KW-1:0]  k_reg, k_next;
   logic [7:0]     si_reg, si_next, sj_reg, sj_next;
   logic [7:0]     f_reg, f_next, enc_reg, enc_next;
   logic           busy_reg, busy_next, done_reg, done_next;
   logic           bad_reg, bad_next;
   mem_sel_t       sel_reg, sel_next;
   logic [7:0]     addr_reg, addr_next, data_reg, data_next;
   logic           wren_reg, wren_next;
   logic [7:0]     plain;
   logic           wait_load, wait_last;

   mem_wait_timer #(.READ_WAIT(READ_WAIT)) u_wait (
      .clk   (clk),
      .reset (reset),
      .load  (wait_load),
      .last  (wait_last)
   );

   always_comb begin
      state_next = state_reg;
      i_next     = i_reg;
      j_next     = j_reg;
      k_next     = k_reg;
      si_next    = si_reg;
      sj_next    = sj_reg;
      f_next     = f_reg;
      enc_next   = enc_reg;
      bad_next   = bad_reg;
      plain      = f_reg ^ enc_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               i_next     = 8'd1;
               j_next     = 8'd0;
               k_next     = '0;
               bad_next   = 1'b0;
               state_next = ST_RD_SI;
            end
         end
         ST_RD_SI: begin
            if (wait_last) begin
               si_next    = rd_data;
               j_next     = j_reg + rd_data;
               state_next = ST_RD_SJ;
            end
         end
         ST_RD_SJ: begin
            if (wait_last) begin
               sj_next    = rd_data;
               state_next = ST_WR_SI;
            end
         end
         ST_WR_SI: state_next = ST_WR_SJ;
         ST_WR_SJ: state_next = ST_RD_F;
         ST_RD_F: begin
            if (wait_last) begin
               f_next     = rd_data;
               state_next = ST_RD_ENC;
            end
         end
         ST_RD_ENC: begin
            if (wait_last) begin
               enc_next   = rd_data;
               state_next = ST_WR_DEC;
            end
         end
         ST_WR_DEC: begin
            state_next = ST_NEXT;
            if (!is_valid_char(plain)) begin
               bad_next = 1'b1;
               if (ABORT_ON_INVALID) state_next = ST_DONE;
            end
         end
         ST_NEXT: begin
            i_next     = i_reg + 8'd1;
            k_next     = k_reg + KW'(1);
            state_next = (k_reg == K_LAST) ? ST_DONE : ST_RD_SI;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase

      // Outputs are registered, so they are derived from the state being entered.
      sel_next  = MEM_NONE;
      addr_next = 8'd0;
      data_next = 8'd0;
      wren_next = 1'b0;
      busy_next = (state_next != ST_IDLE);
      done_next = (state_next == ST_DONE);
      case (state_next)
         ST_RD_SI:  begin sel_next = MEM_S;   addr_next = i_next; end
         ST_RD_SJ:  begin sel_next = MEM_S;   addr_next = j_next; end
         ST_WR_SI:  begin sel_next = MEM_S;   addr_next = i_next; data_next = sj_next; wren_next = 1'b1; end
         ST_WR_SJ:  begin sel_next = MEM_S;   addr_next = j_next; data_next = si_next; wren_next = 1'b1; end
         ST_RD_F:   begin sel_next = MEM_S;   addr_next = si_next + sj_next; end
         ST_RD_ENC: begin sel_next = MEM_ENC; addr_next = 8'(k_next); end
         ST_WR_DEC: begin sel_next = MEM_DEC; addr_next = 8'(k_next); data_next = f_next ^ enc_next; wren_next = 1'b1; end
         default: ;
      endcase

      // Reload the wait counter only on entry to a read state, not while waiting in it.
      wait_load = 1'b0;
      if (state_next != state_reg) begin
         case (state_next)
            ST_RD_SI, ST_RD_SJ, ST_RD_F, ST_RD_ENC: wait_load = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         i_reg     <= 8'd0;
         j_reg     <= 8'd0;
         k_reg     <= '0;
         si_reg    <= 8'd0;
         sj_reg    <= 8'd0;
         f_reg     <= 8'd0;
         enc_reg   <= 8'd0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         bad_reg   <= 1'b0;
         sel_reg   <= MEM_NONE;
         addr_reg  <= 8'd0;
         data_reg  <= 8'd0;
         wren_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         i_reg     <= i_next;
         j_reg     <= j_next;
         k_reg     <= k_next;
         si_reg    <= si_next;
         sj_reg    <= sj_next;
         f_reg     <= f_next;
         enc_reg   <= enc_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         bad_reg   <= bad_next;
         sel_reg   <= sel_next;
         addr_reg  <= addr_next;
         data_reg  <= data_next;
         wren_reg  <= wren_next;
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign bad_char    = bad_reg;
   assign mem_sel     = sel_reg;
   assign mem_address = addr_reg;
   assign mem_data    = data_reg;
   assign mem_wren    = wren_reg;

endmodule

// File: tb/tb_rc4_decrypt_fsm.sv
// Scoreboard bench for rc4_decrypt_fsm. Four instances with different READ_WAIT /
// ABORT_ON_INVALID settings, each with its own S RAM, ROM and RAM model; only one
// instance runs at a time, so a single expected-write queue is shared.
module tb_rc4_decrypt_fsm;

   localparam int NI = 4;

   function automatic int w_of(input int n);
      case (n)
         2: return 0;
         3: return 3;
         default: return 1;
      endcase
   endfunction

   function automatic bit a_of(input int n);
      return (n == 1);
   endfunction

   typedef struct packed {
      logic [1:0] inst;
      logic [4:0] addr;
      logic [7:0] data;
   } sb_item_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NI-1:0] reset_v, start_v, busy_v, done_v, bad_v, wren_v, load_req;
   logic [1:0]    sel_a  [NI];
   logic [7:0]    addr_a [NI];
   logic [7:0]    data_a [NI];
   logic [7:0]    rd_a   [NI];
   logic [7:0]    comb_rd[NI];
   logic [7:0]    hist   [NI][4];
   logic [7:0]    s_mem  [NI][256];
   logic [7:0]    s_init [NI][256];
   logic [7:0]    rom    [NI][32];
   logic [7:0]    ram    [NI][32];
   logic [7:0]    ks     [32];
   int            s_wr_cnt[NI];
   int            dec_wr_cnt[NI];
   int            cyc = 0;
   int            t_acc;
   int            checks = 0;
   int            errors = 0;
   sb_item_t      exp_q[$];

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      rc4_decrypt_fsm #(
         .MSG_LEN          (32),
         .READ_WAIT        (w_of(gi)),
         .ABORT_ON_INVALID (a_of(gi))
      ) u_dut (
         .clk         (clk),
         .reset       (reset_v[gi]),
         .start       (start_v[gi]),
         .busy        (busy_v[gi]),
         .done        (done_v[gi]),
         .bad_char    (bad_v[gi]),
         .mem_sel     (sel_a[gi]),
         .mem_address (addr_a[gi]),
         .mem_data    (data_a[gi]),
         .mem_wren    (wren_v[gi]),
         .rd_data     (rd_a[gi])
      );
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Memory models: comb read, delayed by READ_WAIT cycles through hist.
   always_comb begin
      for (int n = 0; n < NI; n++) begin
         case (sel_a[n])
            2'b01:   comb_rd[n] = s_mem[n][addr_a[n]];
            2'b10:   comb_rd[n] = ram[n][addr_a[n][4:0]];
            2'b11:   comb_rd[n] = rom[n][addr_a[n][4:0]];
            default: comb_rd[n] = 8'h00;
         endcase
         rd_a[n] = (w_of(n) == 0) ? comb_rd[n] : hist[n][(w_of(n) == 0) ? 0 : w_of(n) - 1];
      end
   end

   always @(posedge clk) begin
      for (int n = 0; n < NI; n++) begin
         if (load_req[n]) begin
            for (int m = 0; m < 256; m++) s_mem[n][m] <= s_init[n][m];
            for (int m = 0; m < 32; m++) ram[n][m] <= 8'h00;
            s_wr_cnt[n]   <= 0;
            dec_wr_cnt[n] <= 0;
         end else if (wren_v[n]) begin
            if (sel_a[n] == 2'b01) begin
               s_mem[n][addr_a[n]] <= data_a[n];
               s_wr_cnt[n] <= s_wr_cnt[n] + 1;
            end else if (sel_a[n] == 2'b10) begin
               ram[n][addr_a[n][4:0]] <= data_a[n];
               dec_wr_cnt[n] <= dec_wr_cnt[n] + 1;
            end
         end
         hist[n][0] <= comb_rd[n];
         for (int d = 1; d < 4; d++) hist[n][d] <= hist[n][d-1];
      end
   end

   // Monitor: every decrypted-RAM write is popped from the scoreboard and compared.
   always @(negedge clk) begin
      sb_item_t e;
      for (int n = 0; n < NI; n++) begin
         if (!reset_v[n] && wren_v[n] && sel_a[n] == 2'b10) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: inst %0d wrote addr %0d data %02h, no write expected",
                        n, addr_a[n][4:0], data_a[n]);
            end else begin
               e = exp_q.pop_front();
               if (int'(e.inst) != n || e.addr != addr_a[n][4:0] || e.data != data_a[n]) begin
                  errors++;
                  $display("FAIL sb_write: got inst %0d addr %0d data %02h, expected inst %0d addr %0d data %02h",
                           n, addr_a[n][4:0], data_a[n], e.inst, e.addr, e.data);
               end else begin
                  $display("write inst %0d addr %0d data %02h ok", n, addr_a[n][4:0], data_a[n]);
               end
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end else begin
         $display("check %s = %0d ok", name, act);
      end
   endtask

   // Golden RC4 PRGA keystream from s_init[n].
   task automatic gen_ks(input int n);
      logic [7:0] s [256];
      logic [7:0] i, j, t, idx;
      for (int m = 0; m < 256; m++) s[m] = s_init[n][m];
      i = 8'd0;
      j = 8'd0;
      for (int k = 0; k < 32; k++) begin
         i = i + 8'd1;
         j = j + s[i];
         t = s[i]; s[i] = s[j]; s[j] = t;
         idx = s[i] + s[j];
         ks[k] = s[idx];
      end
   endtask

   task automatic push_expected(input int n, input int count);
      sb_item_t e;
      for (int k = 0; k < count; k++) begin
         e.inst = 2'(n);
         e.addr = 5'(k);
         e.data = ks[k] ^ rom[n][k];
         exp_q.push_back(e);
      end
   endtask

   task automatic load(input int n);
      load_req[n] = 1'b1;
      @(negedge clk);
      load_req[n] = 1'b0;
      @(negedge clk);
   endtask

   task automatic start_run(input int n, input bit hold);
      bit seen = 1'b0;
      start_v[n] = 1'b1;
      for (int c = 0; c < 5 && !seen; c++) begin
         @(negedge clk);
         if (busy_v[n]) seen = 1'b1;
      end
      if (!seen) check("start_accept_timeout", 0, 1);
      t_acc = cyc - 1;
      if (!hold) start_v[n] = 1'b0;
   endtask

   task automatic wait_done(input int n, output int lat);
      bit seen = 1'b0;
      lat = -1;
      for (int c = 0; c < 3000 && !seen; c++) begin
         @(negedge clk);
         if (done_v[n]) begin
            seen = 1'b1;
            lat  = cyc - t_acc;
         end
      end
      if (!seen) check("done_timeout", 0, 1);
   endtask

   initial begin
      int lat;
      int s_before, d_before;
      bit hit;
      reset_v  = '1;
      start_v  = '0;
      load_req = '0;
      for (int n = 0; n < NI; n++) begin
         for (int m = 0; m < 256; m++) s_init[n][m] = 8'(m);
         for (int m = 0; m < 32; m++) rom[n][m] = 8'h00;
      end
      for (int n = 0; n < NI; n++) load(n);
      repeat (2) @(negedge clk);
      for (int n = 0; n < NI; n++) begin
         check($sformatf("reset_busy_%0d", n), busy_v[n], 0);
         check($sformatf("reset_outs_%0d", n),
               int'({done_v[n], bad_v[n], wren_v[n], sel_a[n], addr_a[n], data_a[n]}), 0);
      end
      reset_v = '0;
      @(negedge clk);

      // 1: identity S, zero ROM, no abort, READ_WAIT=1
      gen_ks(0);
      push_expected(0, 32);
      start_run(0, 1'b0);
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge clk);
         if (dec_wr_cnt[0] == 2) hit = 1'b1;
      end
      check("t1_s2_after_byte1", s_mem[0][2], 3);
      check("t1_s3_after_byte1", s_mem[0][3], 2);
      wait_done(0, lat);
      check("t1_latency", lat, 385);
      check("t1_ram0", ram[0][0], 8'h02);
      check("t1_ram1", ram[0][1], 8'h05);
      check("t1_ram_writes", dec_wr_cnt[0], 32);
      check("t1_bad_char", bad_v[0], 1);
      @(negedge clk);
      check("t1_done_one_cycle", done_v[0], 0);
      check("t1_queue_empty", exp_q.size(), 0);

      // 2: plaintext "ab" then spaces, abort enabled, must run to completion
      gen_ks(1);
      for (int k = 0; k < 32; k++) rom[1][k] = 8'h20 ^ ks[k];
      rom[1][0] = 8'h63;
      rom[1][1] = 8'h67;
      load(1);
      push_expected(1, 32);
      start_run(1, 1'b0);
      wait_done(1, lat);
      check("t2_latency", lat, 385);
      check("t2_ram0", ram[1][0], 8'h61);
      check("t2_ram1", ram[1][1], 8'h62);
      check("t2_bad_char", bad_v[1], 0);
      check("t2_ram_writes", dec_wr_cnt[1], 32);
      check("t2_queue_empty", exp_q.size(), 0);

      // 3: zero ROM with abort: stops after the first byte
      for (int k = 0; k < 32; k++) rom[1][k] = 8'h00;
      load(1);
      gen_ks(1);
      push_expected(1, 1);
      start_run(1, 1'b0);
      wait_done(1, lat);
      check("t3_latency", lat, 12);
      check("t3_bad_char", bad_v[1], 1);
      check("t3_ram_writes", dec_wr_cnt[1], 1);
      check("t3_s_writes", s_wr_cnt[1], 2);
      check("t3_queue_empty", exp_q.size(), 0);

      // 4: reset while in RD_F of byte 3
      load(0);
      gen_ks(0);
      push_expected(0, 3);
      start_run(0, 1'b0);
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         @(negedge clk);
         if (s_wr_cnt[0] >= 8) hit = 1'b1;
      end
      check("t4_in_rd_f", int'({sel_a[0], wren_v[0]}), 2);
      reset_v[0] = 1'b1;
      @(negedge clk);
      check("t4_busy_after_reset", busy_v[0], 0);
      check("t4_outs_after_reset",
            int'({done_v[0], bad_v[0], wren_v[0], sel_a[0], addr_a[0], data_a[0]}), 0);
      reset_v[0] = 1'b0;
      s_before = s_wr_cnt[0];
      d_before = dec_wr_cnt[0];
      repeat (20) @(negedge clk);
      check("t4_no_s_writes_after", s_wr_cnt[0] - s_before, 0);
      check("t4_no_ram_writes_after", dec_wr_cnt[0] - d_before, 0);
      check("t4_ram_writes", d_before, 3);
      check("t4_idle", busy_v[0], 0);
      check("t4_queue_empty", exp_q.size(), 0);

      // 5: start held high plus a re-pulse mid-run
      load(0);
      gen_ks(0);
      push_expected(0, 32);
      start_run(0, 1'b1);
      repeat (100) @(negedge clk);
      start_v[0] = 1'b0;
      repeat (3) @(negedge clk);
      start_v[0] = 1'b1;
      wait_done(0, lat);
      check("t5_latency", lat, 385);
      check("t5_ram_writes", dec_wr_cnt[0], 32);
      @(negedge clk);
      check("t5_idle_busy", busy_v[0], 0);
      check("t5_bad_sticky", bad_v[0], 1);
      @(negedge clk);
      check("t5_restart_busy", busy_v[0], 1);
      check("t5_bad_cleared", bad_v[0], 0);
      start_v[0] = 1'b0;
      reset_v[0] = 1'b1;
      @(negedge clk);
      reset_v[0] = 1'b0;
      check("t5_queue_empty", exp_q.size(), 0);

      // 6: permuted S, random ROM, READ_WAIT=0 and READ_WAIT=3
      for (int n = 2; n < 4; n++) begin
         for (int m = 0; m < 256; m++) s_init[n][m] = 8'(m * 7 + 3);
         for (int k = 0; k < 32; k++) rom[n][k] = 8'($urandom_range(0, 255));
         load(n);
         gen_ks(n);
         push_expected(n, 32);
         start_run(n, 1'b0);
         wait_done(n, lat);
         check($sformatf("t6_latency_w%0d", w_of(n)), lat, 32 * (4 * (1 + w_of(n)) + 4) + 1);
         check($sformatf("t6_ram_writes_w%0d", w_of(n)), dec_wr_cnt[n], 32);
         check($sformatf("t6_queue_empty_w%0d", w_of(n)), exp_q.size(), 0);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
